// File: rtl/zero_count_stream.sv
// Streaming trailing/leading zero counter: accepts one word per handshake and scans it
// SLICE_WIDTH bits per cycle, producing the count with full valid/ready back-pressure.
module zero_count_stream #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SLICE_WIDTH = 8,
    localparam int unsigned CW         = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  mode,
    input  logic                  din_vld,
    output logic                  din_rdy,
    output logic [CW-1:0]         dout,
    output logic                  dout_zero,
    output logic                  dout_vld,
    input  logic                  dout_rdy
);

    localparam int unsigned NSLICE = DATA_WIDTH / SLICE_WIDTH;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   word, word_next;
    logic [IW-1:0]           idx, idx_next;
    logic [CW-1:0]           acc, acc_next;
    logic [CW-1:0]           dout_next;
    logic                    dout_zero_next;
    logic                    din_rdy_next;
    logic                    dout_vld_next;
    logic [SLICE_WIDTH-1:0]  slice;

    // Leading-zero requests are stored mirrored so the scan always runs from bit 0.
    function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(DATA_WIDTH); i++) begin
            r[i] = d[int'(DATA_WIDTH) - 1 - i];
        end
        return r;
    endfunction

    // Trailing zeros of a nonzero slice; the lowest set bit wins.
    function automatic logic [CW-1:0] slice_tz(input logic [SLICE_WIDTH-1:0] s);
        logic [CW-1:0] tz;
        tz = '0;
        for (int i = int'(SLICE_WIDTH) - 1; i >= 0; i--) begin
            if (s[i]) begin
                tz = CW'(i);
            end
        end
        return tz;
    endfunction

    // The stored word is shifted down each scan cycle, so the current slice is always at the bottom.
    assign slice = word[SLICE_WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            word      <= '0;
            idx       <= '0;
            acc       <= '0;
            dout      <= '0;
            dout_zero <= 1'b0;
            din_rdy   <= 1'b1;
            dout_vld  <= 1'b0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            idx       <= idx_next;
            acc       <= acc_next;
            dout      <= dout_next;
            dout_zero <= dout_zero_next;
            din_rdy   <= din_rdy_next;
            dout_vld  <= dout_vld_next;
        end
    end

    always_comb begin
        state_next     = state;
        word_next      = word;
        idx_next       = idx;
        acc_next       = acc;
        dout_next      = dout;
        dout_zero_next = dout_zero;

        unique case (state)
            IDLE: begin
                if (din_vld && din_rdy) begin
                    word_next  = mode ? bit_reverse(din) : din;
                    idx_next   = '0;
                    acc_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (|slice) begin
                    dout_next      = acc + slice_tz(slice);
                    dout_zero_next = 1'b0;
                    state_next     = DONE;
                end else if (idx == IW'(NSLICE - 1)) begin
                    dout_next      = CW'(DATA_WIDTH);
                    dout_zero_next = 1'b1;
                    state_next     = DONE;
                end else begin
                    acc_next  = acc + CW'(SLICE_WIDTH);
                    idx_next  = idx + IW'(1);
                    word_next = word >> SLICE_WIDTH;
                end
            end
            DONE: begin
                if (dout_vld && dout_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next state, never of the inputs.
        din_rdy_next  = (state_next == IDLE);
        dout_vld_next = (state_next == DONE);
    end

endmodule
